uart_rx_fifo: RTL and testbench

- Receive-side byte buffer directly downstream of the UART receiver.
- Captures each single-cycle data-valid pulse and its byte into a circular FIFO.
- Exposes a read handshake to the consumer logic (command decoder, loopback TX), so bytes are not lost while the consumer is busy.
- Tracks fill level and flags overflow when the receiver delivers a byte into a full buffer.

---
 rtl/uart_rx_fifo.sv | 146 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   Receive-side byte buffer placed directly after the UART receiver. Each
//   one-cycle data-valid pulse from the receiver stores its byte in a
//   circular FIFO. The consumer drains the FIFO through a read handshake.
//   The block tracks the fill level and raises a sticky overflow flag when
//   a byte arrives while the buffer is full.
//
//   Build option (macro UART_RX_FIFO_FWFT_EN):
//     defined   - first-word fall-through. The head entry is always
//                 presented on o_Rd_Byte, o_Rd_Valid = ~o_Empty, and
//                 i_Rd_En acknowledges and pops the head (latency 0).
//     undefined - standard mode. An accepted read registers the head entry
//                 into o_Rd_Byte and pulses o_Rd_Valid for one cycle
//                 (latency 1). o_Rd_Byte holds its value between reads.
//
// Ports:
//   i_Clock        system clock, shared with the receiver
//   i_Reset        synchronous, active-high reset
//   i_Rx_DV        write strobe (one-cycle pulse per received byte)
//   i_Rx_Byte      received byte, sampled when i_Rx_DV=1
//   i_Rd_En        consumer pop request, ignored while empty
//   o_Rd_Byte      read data
//   o_Rd_Valid     read data valid
//   o_Empty        no entries stored
//   o_Full         all 2**DEPTH_LOG2 entries in use
//   o_Count        number of stored entries
//   o_Overflow     sticky: a byte was dropped
//   i_Clr_Overflow clears o_Overflow (a drop in the same cycle wins)
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_Rx_DV,
    input  logic [DATA_WIDTH-1:0] i_Rx_Byte,
    input  logic                  i_Rd_En,
    output logic [DATA_WIDTH-1:0] o_Rd_Byte,
    output logic                  o_Rd_Valid,
    output logic                  o_Empty,
    output logic                  o_Full,
    output logic [DEPTH_LOG2:0]   o_Count,
    output logic                  o_Overflow,
    input  logic                  i_Clr_Overflow
);

    localparam int                   DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_overflow;

    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_drop;
    logic [DEPTH_LOG2:0]   w_count_nxt;

    // A write into a full FIFO is still accepted when a read frees a slot
    // in the same cycle.
    assign w_rd_acc = i_Rd_En & ~r_empty;
    assign w_wr_acc = i_Rx_DV & (~r_full | w_rd_acc);
    assign w_drop   = i_Rx_DV & ~w_wr_acc;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage has no reset. The write is gated by reset so that a byte
    // arriving in the reset cycle is discarded.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset && w_wr_acc) begin
            r_mem[r_wr_ptr] <= i_Rx_Byte;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == FULL_COUNT);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_Clr_Overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

`ifdef UART_RX_FIFO_FWFT_EN
    // Head entry shown directly from the array; forced to zero while empty
    // so the output is defined after reset.
    assign o_Rd_Byte  = r_empty ? '0 : r_mem[r_rd_ptr];
    assign o_Rd_Valid = ~r_empty;
`else
    logic [DATA_WIDTH-1:0] r_rd_byte;
    logic                  r_rd_valid;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_rd_byte  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_byte <= r_mem[r_rd_ptr];
            end
        end
    end

    assign o_Rd_Byte  = r_rd_byte;
    assign o_Rd_Valid = r_rd_valid;
`endif

    assign o_Empty    = r_empty;
    assign o_Full     = r_full;
    assign o_Count    = r_count;
    assign o_Overflow = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_dv = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rd_en = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [7:0] rd_byte;
    logic       rd_valid;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       ovf;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DEPTH_LOG2 (2),
        .DATA_WIDTH (8)
    ) dut (
        .i_Clock        (clk),
        .i_Reset        (rst),
        .i_Rx_DV        (rx_dv),
        .i_Rx_Byte      (rx_byte),
        .i_Rd_En        (rd_en),
        .o_Rd_Byte      (rd_byte),
        .o_Rd_Valid     (rd_valid),
        .o_Empty        (empty),
        .o_Full         (full),
        .o_Count        (count),
        .o_Overflow     (ovf),
        .i_Clr_Overflow (clr_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_dv   = 1'b1;
        rx_byte = b;
        tick();
        rx_dv   = 1'b0;
    endtask

    // Pops one entry and returns what the read port showed for it:
    // before the edge in fall-through mode, after the edge otherwise.
    task automatic pop(output logic [7:0] b, output logic v);
        rd_en = 1'b1;
`ifdef UART_RX_FIFO_FWFT_EN
        b = rd_byte;
        v = rd_valid;
        tick();
`else
        tick();
        b = rd_byte;
        v = rd_valid;
`endif
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags count=%0d empty=%0b full=%0b want 0/1/0", count, empty, full);
        end
        checks++;
        if (ovf !== 1'b0 || rd_valid !== 1'b0 || rd_byte !== 8'h00) begin
            failures++;
            $display("FAIL reset_rd ovf=%0b valid=%0b byte=%02h want 0/0/00", ovf, rd_valid, rd_byte);
        end
    endtask

    task automatic test_basic();
        logic [7:0] b;
        logic       v;
        logic [7:0] exp [3];
        exp[0] = 8'h41; exp[1] = 8'h42; exp[2] = 8'h43;
        for (int i = 0; i < 3; i++) begin
            push(exp[i]);
            checks++;
            if (count !== 3'(i + 1)) begin
                failures++;
                $display("FAIL basic_count got=%0d want=%0d", count, i + 1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            pop(b, v);
            checks++;
            if (b !== exp[i] || v !== 1'b1) begin
                failures++;
                $display("FAIL basic_read got=%02h valid=%0b want=%02h valid=1", b, v, exp[i]);
            end
            tick();
`ifndef UART_RX_FIFO_FWFT_EN
            checks++;
            if (rd_valid !== 1'b0 || rd_byte !== exp[i]) begin
                failures++;
                $display("FAIL basic_pulse valid=%0b byte=%02h want valid=0 byte=%02h", rd_valid, rd_byte, exp[i]);
            end
`endif
        end
        checks++;
        if (empty !== 1'b1 || count !== 3'd0 || rd_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_end empty=%0b count=%0d valid=%0b want 1/0/0", empty, count, rd_valid);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        logic       v;
        for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
        checks++;
        if (full !== 1'b1 || count !== 3'd4 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_fill full=%0b count=%0d ovf=%0b want 1/4/0", full, count, ovf);
        end
        push(8'h14);
        checks++;
        if (full !== 1'b1 || count !== 3'd4 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_drop full=%0b count=%0d ovf=%0b want 1/4/1", full, count, ovf);
        end
        for (int i = 0; i < 4; i++) begin
            pop(b, v);
            checks++;
            if (b !== 8'h10 + 8'(i) || v !== 1'b1) begin
                failures++;
                $display("FAIL ovf_read got=%02h valid=%0b want=%02h valid=1", b, v, 8'h10 + 8'(i));
            end
        end
        tick();
        checks++;
        if (empty !== 1'b1 || ovf !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky empty=%0b ovf=%0b want 1/1", empty, ovf);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear ovf=%0b want 0", ovf);
        end
    endtask

    task automatic test_full_rw();
        logic [7:0] b;
        logic       v;
        for (int i = 0; i < 4; i++) push(8'h20 + 8'(i));
        rx_dv   = 1'b1;
        rx_byte = 8'h24;
        pop(b, v);
        rx_dv   = 1'b0;
        checks++;
        if (b !== 8'h20 || v !== 1'b1) begin
            failures++;
            $display("FAIL fullrw_read got=%02h valid=%0b want=20 valid=1", b, v);
        end
        checks++;
        if (count !== 3'd4 || ovf !== 1'b0 || full !== 1'b1) begin
            failures++;
            $display("FAIL fullrw_state count=%0d ovf=%0b full=%0b want 4/0/1", count, ovf, full);
        end
        for (int i = 1; i < 5; i++) begin
            pop(b, v);
            checks++;
            if (b !== 8'h20 + 8'(i) || v !== 1'b1) begin
                failures++;
                $display("FAIL fullrw_drain got=%02h valid=%0b want=%02h valid=1", b, v, 8'h20 + 8'(i));
            end
        end
        tick();
        checks++;
        if (empty !== 1'b1 || ovf !== 1'b0) begin
            failures++;
            $display("FAIL fullrw_end empty=%0b ovf=%0b want 1/0", empty, ovf);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] b;
        logic       v;
        for (int i = 0; i < 10; i++) begin
            push(8'(i));
            checks++;
            if (count !== 3'd1) begin
                failures++;
                $display("FAIL wrap_count got=%0d want=1", count);
            end
            pop(b, v);
            checks++;
            if (b !== 8'(i) || v !== 1'b1) begin
                failures++;
                $display("FAIL wrap_read got=%02h valid=%0b want=%02h valid=1", b, v, 8'(i));
            end
        end
        tick();
        checks++;
        if (empty !== 1'b1 || ovf !== 1'b0 || count !== 3'd0) begin
            failures++;
            $display("FAIL wrap_end empty=%0b ovf=%0b count=%0d want 1/0/0", empty, ovf, count);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        logic       v;
        push(8'h55);
        push(8'h66);
        rst     = 1'b1;
        rx_dv   = 1'b1;
        rx_byte = 8'h77;
        tick();
        rst   = 1'b0;
        rx_dv = 1'b0;
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || rd_byte !== 8'h00) begin
            failures++;
            $display("FAIL midrst_state count=%0d empty=%0b valid=%0b byte=%02h want 0/1/0/00",
                     count, empty, rd_valid, rd_byte);
        end
        pop(b, v);
        checks++;
        if (v !== 1'b0 || b !== 8'h00 || count !== 3'd0 || empty !== 1'b1) begin
            failures++;
            $display("FAIL midrst_read valid=%0b byte=%02h count=%0d empty=%0b want 0/00/0/1",
                     v, b, count, empty);
        end
    endtask

    task automatic test_edges();
        logic [7:0] b;
        logic       v;
        push(8'h5A);
        pop(b, v);
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        checks++;
`ifdef UART_RX_FIFO_FWFT_EN
        if (rd_byte !== 8'h00 || rd_valid !== 1'b0 || count !== 3'd0) begin
            failures++;
            $display("FAIL edge_underflow byte=%02h valid=%0b count=%0d want 00/0/0", rd_byte, rd_valid, count);
        end
`else
        if (rd_byte !== 8'h5A || rd_valid !== 1'b0 || count !== 3'd0) begin
            failures++;
            $display("FAIL edge_underflow byte=%02h valid=%0b count=%0d want 5a/0/0", rd_byte, rd_valid, count);
        end
`endif
        rx_dv   = 1'b1;
        rx_byte = 8'h33;
        rd_en   = 1'b1;
        tick();
        rx_dv = 1'b0;
        rd_en = 1'b0;
        checks++;
        if (count !== 3'd1 || empty !== 1'b0) begin
            failures++;
            $display("FAIL edge_wr_empty count=%0d empty=%0b want 1/0", count, empty);
        end
        for (int i = 0; i < 3; i++) push(8'hC0 + 8'(i));
        rx_dv   = 1'b1;
        rx_byte = 8'hEE;
        clr_ovf = 1'b1;
        tick();
        rx_dv   = 1'b0;
        clr_ovf = 1'b0;
        checks++;
        if (ovf !== 1'b1 || count !== 3'd4) begin
            failures++;
            $display("FAIL edge_drop_clr ovf=%0b count=%0d want 1/4", ovf, count);
        end
        pop(b, v);
        checks++;
        if (b !== 8'h33 || v !== 1'b1) begin
            failures++;
            $display("FAIL edge_head got=%02h valid=%0b want=33 valid=1", b, v);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_rw();
        test_wrap();
        test_reset_mid();
        test_edges();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
